sq_diff_serial: RTL

- Parametrised, sequential successor to the fixed 6-bit combinational squared-difference evaluators.
- Computes (a-b)^2 for unsigned W-bit operands with a shift-add datapath, one partial product per cycle.
- Runtime truncation control masks low partial-product columns, giving exact or approximate squaring from one block.
- Optionally accumulates results into a saturating sum-of-squared-differences (SSD) register for error-evaluation benches.

---
 rtl/sq_diff_serial.sv | 89 ++++++++
 1 files changed

// File: rtl/sq_diff_serial.sv
// sq_diff_serial: serial shift-add (a-b)^2 with column truncation and saturating SSD accumulator
module sq_diff_serial #(
  parameter int W     = 6,
  parameter int TW    = 4,
  parameter int ACC_W = 2*W+8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [W-1:0]       a,
  input  logic [W-1:0]       b,
  input  logic [TW-1:0]      trunc,
  input  logic               acc_en,
  input  logic               acc_clr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*W-1:0]     sq,
  output logic [ACC_W-1:0]   ssd,
  output logic               ovf
);
  localparam int IW = $clog2(W+1);
  typedef enum logic [1:0] {IDLE, DIFF, MUL, DONE} state_t;
  state_t state, state_n;
  logic [W-1:0]     a_r, b_r, d;
  logic [TW-1:0]    trunc_r;
  logic             acc_en_r, fin, bit_set;
  logic [2*W-1:0]   acc, pp;
  logic [IW-1:0]    i;
  logic [ACC_W:0]   sum;
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  // MUL spends one extra cycle (i == W) to register the finished product into sq
  assign fin     = state == MUL && i == IW'(W);
  assign bit_set = |(d & (W'(1) << i));
  assign pp      = bit_set ? (({{W{1'b0}}, d} << i) & ({(2*W){1'b1}} << trunc_r)) : '0;
  assign sum     = {1'b0, ssd} + (ACC_W+1)'(acc);
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = in_valid ? DIFF : IDLE;
      DIFF: state_n = MUL;
      MUL:  state_n = fin ? DONE : MUL;
      DONE: state_n = out_ready ? IDLE : DONE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r <= '0;
      b_r <= '0;
      d <= '0;
      trunc_r <= '0;
      acc_en_r <= 1'b0;
      acc <= '0;
      i <= '0;
      sq <= '0;
      ssd <= '0;
      ovf <= 1'b0;
    end else begin
      if (state == IDLE && in_valid) begin
        a_r <= a;
        b_r <= b;
        trunc_r <= trunc;
        acc_en_r <= acc_en;
      end
      if (state == DIFF) begin
        d <= a_r > b_r ? a_r - b_r : b_r - a_r;
        acc <= '0;
        i <= '0;
      end
      if (state == MUL && !fin) begin
        acc <= acc + pp;
        i <= i + 1'b1;
      end
      if (fin) sq <= acc;
      if (fin && acc_en_r) begin
        ssd <= acc_clr ? ACC_W'(acc) : sum[ACC_W] ? '1 : sum[ACC_W-1:0];
        ovf <= !acc_clr && (ovf || sum[ACC_W]);
      end else if (acc_clr) begin
        ssd <= '0;
        ovf <= 1'b0;
      end
    end
  end
endmodule
